// File: rtl/rom_dl_ctrl_if.sv
// Download/auxiliary write bus between hps_io, rom_dl_ctrl and the core write port.
// master = requester side (hps_io + aux port), slave = rom_dl_ctrl.
interface rom_dl_ctrl_if;
    // Handshake: ioctl_wr and dn_wr are one-cycle strobes with no back-pressure;
    // aux_req is a level request (valid) and aux_ack a one-cycle pulse (ready)
    // marking the cycle the aux address/data were issued on dn_*.
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        aux_req;
    logic [16:0] aux_addr;
    logic [7:0]  aux_data;
    logic        aux_ack;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output aux_req, aux_addr, aux_data,
        input  aux_ack, dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  aux_req, aux_addr, aux_data,
        output aux_ack, dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: muxes ioctl bytes and aux NVRAM writes onto the core write
// port and holds the core in reset while loading. Optional checksum: DL_CHECKSUM_EN.
module rom_dl_ctrl #(
    parameter int unsigned ROM_BYTES   = 32'h18000,
    parameter int unsigned HOLD_CYCLES = 256,
    parameter logic [7:0]  EXP_CSUM    = 8'h00
) (
    input  logic          clk_sys,
    input  logic          reset,
    rom_dl_ctrl_if.slave  bus,
    output logic          core_reset,
    output logic          done,
    output logic          overflow,
    output logic [7:0]    csum,
    output logic          csum_ok,
    output logic [1:0]    state_dbg
);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [24:0] ROM_LIMIT   = 25'(ROM_BYTES);
    localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dl_q;
    logic        dn_wr_q, dn_wr_d;
    logic [16:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic        aux_ack_q, aux_ack_d;
    logic        overflow_q, overflow_d;

    logic dl_rise;
    logic in_range;
    logic dl_accept;
    logic load_entry;

    assign dl_rise    = bus.ioctl_download & ~dl_q;
    // Full 25-bit compare so high address bits cannot alias into the ROM window.
    assign in_range   = (bus.ioctl_addr < ROM_LIMIT);
    assign dl_accept  = (state_q == ST_LOAD) && bus.ioctl_wr && in_range;
    assign load_entry = (state_q != ST_LOAD) && dl_rise;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dn_wr_d    = 1'b0;
        aux_ack_d  = 1'b0;
        dn_addr_d  = dn_addr_q;
        dn_data_d  = dn_data_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_HOLD: begin
                if (dl_rise) begin
                    state_d    = ST_LOAD;
                    overflow_d = 1'b0;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            ST_LOAD: begin
                if (dl_accept) begin
                    dn_wr_d   = 1'b1;
                    dn_addr_d = bus.ioctl_addr[16:0];
                    dn_data_d = bus.ioctl_dout;
                end else if (bus.ioctl_wr) begin
                    overflow_d = 1'b1;
                end
                // A byte strobed alongside the falling edge is still written above.
                if (!bus.ioctl_download) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_RELOAD;
                end
            end

            ST_RUN: begin
                if (dl_rise) begin
                    state_d    = ST_LOAD;
                    overflow_d = 1'b0;
                end else if (bus.aux_req && !dn_wr_q) begin
                    dn_wr_d   = 1'b1;
                    aux_ack_d = 1'b1;
                    dn_addr_d = bus.aux_addr;
                    dn_data_d = bus.aux_data;
                end
            end

            default: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_RELOAD;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_HOLD;
            cnt_q      <= HOLD_RELOAD;
            dl_q       <= 1'b0;
            dn_wr_q    <= 1'b0;
            dn_addr_q  <= 17'd0;
            dn_data_q  <= 8'd0;
            aux_ack_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dl_q       <= bus.ioctl_download;
            dn_wr_q    <= dn_wr_d;
            dn_addr_q  <= dn_addr_d;
            dn_data_q  <= dn_data_d;
            aux_ack_q  <= aux_ack_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.dn_wr   = dn_wr_q;
    assign bus.dn_addr = dn_addr_q;
    assign bus.dn_data = dn_data_q;
    assign bus.aux_ack = aux_ack_q;

    assign core_reset = (state_q != ST_RUN);
    assign done       = (state_q == ST_RUN);
    assign overflow   = overflow_q;
    assign state_dbg  = state_q;

`ifdef DL_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Only accepted download bytes count; aux writes never touch the sum.
    always_comb begin
        csum_d = csum_q;
        if (load_entry) begin
            csum_d = 8'd0;
        end else if (dl_accept) begin
            csum_d = csum_q + bus.ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum    = csum_q;
    assign csum_ok = (csum_q == EXP_CSUM) && done;
`else
    // Without the accumulator the expected value has no role; the sum reads as zero.
    localparam logic [7:0] CSUM_TIE = EXP_CSUM & 8'h00;

    logic unused_load_entry;
    assign unused_load_entry = load_entry;

    assign csum    = CSUM_TIE;
    assign csum_ok = 1'b1;
`endif

endmodule
